cycle_counter: RTL and testbench



---
 rtl/cycle_counter_pkg.sv | 8 +
 rtl/cycle_counter.sv | 81 ++++++++
 tb/tb_cycle_counter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cycle_counter_pkg.sv
// Shared CPU package: cycle counter width and the cycle_t type used for ret_val.
package cycle_counter_pkg;

    localparam int CYCLE_COUNTER_WIDTH = 32;

    typedef logic [CYCLE_COUNTER_WIDTH-1:0] cycle_t;

endpackage

// File: rtl/cycle_counter.sv
// Enable-qualified cycle counter that freezes while halted; sticky wrap flag.
// Optional macro CYCLE_COUNTER_WIDE_EN widens the counter to 64 bits (count_hi).
module cycle_counter
    import cycle_counter_pkg::*;
#(
    parameter int WIDTH = CYCLE_COUNTER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt,
    input  logic             en,
    input  logic             clr,
`ifdef CYCLE_COUNTER_WIDE_EN
    output logic [31:0]      count,
    output logic [31:0]      count_hi,
`else
    output logic [WIDTH-1:0] count,
`endif
    output logic             wrap,
    output logic             halt_pulse
);

`ifdef CYCLE_COUNTER_WIDE_EN
    localparam int CW = 64;
`else
    localparam int CW = WIDTH;
`endif

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW:0]   inc;
    logic          wrap_q;
    logic          wrap_d;
    logic          hist_q;
    logic          hist_d;
    logic          pulse_q;
    logic          pulse_d;

    assign inc = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};

    always_comb begin
        cnt_d   = cnt_q;
        wrap_d  = wrap_q;
        hist_d  = halt;
        pulse_d = halt & ~hist_q;
        if (clr) begin
            cnt_d  = '0;
            wrap_d = 1'b0;
        end else if (en && !halt) begin
            cnt_d = inc[CW-1:0];
            // Carry out of the full counter marks the wrap.
            if (inc[CW]) begin
                wrap_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            hist_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            hist_q  <= hist_d;
            pulse_q <= pulse_d;
        end
    end

`ifdef CYCLE_COUNTER_WIDE_EN
    assign count    = cnt_q[31:0];
    assign count_hi = cnt_q[63:32];
`else
    assign count    = cnt_q;
`endif
    assign wrap       = wrap_q;
    assign halt_pulse = pulse_q;

endmodule

// File: tb/tb_cycle_counter.sv
// Directed and random checks of cycle_counter against an edge-count model.
module tb_cycle_counter;

`ifdef CYCLE_COUNTER_WIDE_EN
    localparam int W = 32;
`else
    localparam int W = 8;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          halt = 1'b0;
    logic          en = 1'b0;
    logic          clr = 1'b0;
    logic [W-1:0]  count;
    logic          wrap;
    logic          halt_pulse;
`ifdef CYCLE_COUNTER_WIDE_EN
    logic [31:0]   count_hi;
`endif

    int errors = 0;
    int checks = 0;

    longint unsigned n = 0;
    bit              prev_halt = 1'b0;
    bit              exp_pulse = 1'b0;

    cycle_counter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .halt       (halt),
        .en         (en),
        .clr        (clr),
        .count      (count),
`ifdef CYCLE_COUNTER_WIDE_EN
        .count_hi   (count_hi),
`endif
        .wrap       (wrap),
        .halt_pulse (halt_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_count();
        longint unsigned m;
`ifdef CYCLE_COUNTER_WIDE_EN
        m = n;
`else
        m = n % (64'd1 << W);
`endif
        return m;
    endfunction

    function automatic bit exp_wrap();
`ifdef CYCLE_COUNTER_WIDE_EN
        return 1'b0;
`else
        return n >= (64'd1 << W);
`endif
    endfunction

    task automatic step(input bit r, input bit c, input bit h, input bit e);
        rst  = r;
        clr  = c;
        halt = h;
        en   = e;
        @(posedge clk);
        if (r) begin
            n         = 0;
            prev_halt = 1'b0;
            exp_pulse = 1'b0;
        end else begin
            exp_pulse = h && !prev_halt;
            prev_halt = h;
            if (c) n = 0;
            else if (e && !h) n++;
        end
        #1;
        chk("count", {{(64-W){1'b0}}, count}, exp_count() & ((64'd1 << W) - 1));
`ifdef CYCLE_COUNTER_WIDE_EN
        chk("count_hi", {32'd0, count_hi}, {32'd0, exp_count() >> 32});
`endif
        chk("wrap", {63'd0, wrap}, {63'd0, exp_wrap()});
        chk("halt_pulse", {63'd0, halt_pulse}, {63'd0, exp_pulse});
    endtask

    initial begin
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("reset_count", {{(64-W){1'b0}}, count}, 64'd0);
        chk("reset_flags", {62'd0, wrap, halt_pulse}, 64'd0);

        for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
        chk("ten_edges", {{(64-W){1'b0}}, count}, 64'd10);

        step(0, 1, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, (i % 2) == 0);
        chk("en_toggle", {{(64-W){1'b0}}, count}, 64'd4);
        step(0, 0, 1, 1);
        chk("halt_first", {63'd0, halt_pulse}, 64'd1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        chk("halt_frozen", {{(64-W){1'b0}}, count}, 64'd4);
        chk("halt_once", {63'd0, halt_pulse}, 64'd0);
        step(0, 0, 0, 1);
        chk("halt_resume", {{(64-W){1'b0}}, count}, 64'd5);

        step(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        step(0, 1, 0, 1);
        chk("clr_wins", {{(64-W){1'b0}}, count}, 64'd0);
        step(0, 0, 0, 1);
        chk("after_clr", {{(64-W){1'b0}}, count}, 64'd1);

        step(0, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
        step(1, 0, 1, 1);
        chk("rst_mid", {{(64-W){1'b0}}, count}, 64'd0);
        chk("rst_no_pulse", {63'd0, halt_pulse}, 64'd0);
        step(0, 0, 1, 1);
        chk("post_rst_pulse", {63'd0, halt_pulse}, 64'd1);
        step(0, 0, 1, 1);
        chk("post_rst_once", {63'd0, halt_pulse}, 64'd0);

`ifndef CYCLE_COUNTER_WIDE_EN
        step(0, 1, 0, 0);
        for (int i = 0; i < 255; i++) step(0, 0, 0, 1);
        chk("pre_wrap", {{(64-W){1'b0}}, count}, 64'd255);
        chk("pre_wrap_flag", {63'd0, wrap}, 64'd0);
        step(0, 0, 0, 1);
        chk("wrap_count", {{(64-W){1'b0}}, count}, 64'd0);
        chk("wrap_set", {63'd0, wrap}, 64'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        chk("wrap_sticky", {63'd0, wrap}, 64'd1);
        step(0, 1, 0, 0);
        chk("wrap_clr", {63'd0, wrap}, 64'd0);
`endif

        for (int i = 0; i < 600; i++) begin
            step(($urandom % 64) == 0, ($urandom % 40) == 0,
                 ($urandom % 4) == 0, ($urandom % 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
